// File: rtl/priv_trap_sequencer_if.sv
// rtl/priv_trap_sequencer_if.sv - hazard/CSR <-> trap sequencer signal bundle
//
// Groups the hazard-unit trigger inputs, the CSR read values used for the
// redirect target, the redirect handshake back to hazard and the CSR write
// strobes. The master modport is the hazard unit + CSR file side; the slave
// modport is the trap sequencer itself.
//   trigger flags : fault_insn mal_insn illegal_insn fault_l mal_l fault_s mal_s
//                   breakpoint env fault_insn_page fault_load_page fault_store_page
//                   mret timer_int soft_int ext_int mstatus_mie mie_en[2:0]
//   capture data  : epc[31:0] badaddr[31:0]
//   drain control : pipe_clear ex_mem_stall
//   CSR reads     : mtvec[31:0] mepc_r[31:0]
//   redirect      : priv_pc[31:0] insert_pc intr busy
//   CSR writes    : mepc/mcause/mtval _wen and _wdata[31:0], mstatus_push, mstatus_pop
interface priv_trap_sequencer_if;
    logic        fault_insn;
    logic        mal_insn;
    logic        illegal_insn;
    logic        fault_l;
    logic        mal_l;
    logic        fault_s;
    logic        mal_s;
    logic        breakpoint;
    logic        env;
    logic        fault_insn_page;
    logic        fault_load_page;
    logic        fault_store_page;
    logic        mret;
    logic        pipe_clear;
    logic        ex_mem_stall;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic        timer_int;
    logic        soft_int;
    logic        ext_int;
    logic        mstatus_mie;
    logic [2:0]  mie_en;
    logic [31:0] mtvec;
    logic [31:0] mepc_r;

    logic [31:0] priv_pc;
    logic        insert_pc;
    logic        intr;
    logic        busy;
    logic        mepc_wen;
    logic        mcause_wen;
    logic        mtval_wen;
    logic [31:0] mepc_wdata;
    logic [31:0] mcause_wdata;
    logic [31:0] mtval_wdata;
    logic        mstatus_push;
    logic        mstatus_pop;

    modport master (
        output fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
        output breakpoint, env, fault_insn_page, fault_load_page, fault_store_page,
        output mret, pipe_clear, ex_mem_stall, epc, badaddr,
        output timer_int, soft_int, ext_int, mstatus_mie, mie_en, mtvec, mepc_r,
        input  priv_pc, insert_pc, intr, busy,
        input  mepc_wen, mcause_wen, mtval_wen, mepc_wdata, mcause_wdata, mtval_wdata,
        input  mstatus_push, mstatus_pop
    );

    modport slave (
        input  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
        input  breakpoint, env, fault_insn_page, fault_load_page, fault_store_page,
        input  mret, pipe_clear, ex_mem_stall, epc, badaddr,
        input  timer_int, soft_int, ext_int, mstatus_mie, mie_en, mtvec, mepc_r,
        output priv_pc, insert_pc, intr, busy,
        output mepc_wen, mcause_wen, mtval_wen, mepc_wdata, mcause_wdata, mtval_wdata,
        output mstatus_push, mstatus_pop
    );
endinterface

// File: rtl/priv_trap_sequencer.sv
// rtl/priv_trap_sequencer.sv - machine-mode trap entry / mret sequencer
//
// Captures the highest-priority exception, enabled interrupt or mret while
// idle, waits for the pipeline to drain, commits the CSR updates for one cycle
// and then pulses the PC redirect back to the hazard unit for one cycle.
//   clk_i    : clock, all state on the rising edge
//   rst_i    : synchronous reset, active-high
//   trap_if  : priv_trap_sequencer_if.slave (triggers, drain control, CSR
//              reads in; redirect and CSR write strobes out, all registered)
module priv_trap_sequencer #(
    parameter bit VECTORED_EN = 1'b1,
    parameter int WAIT_MAX    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    priv_trap_sequencer_if.slave  trap_if
);

    localparam int               CNT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_CLEAR,
        ST_COMMIT,
        ST_REDIRECT
    } state_t;

    typedef enum logic [1:0] {
        KIND_EXC,
        KIND_IRQ,
        KIND_RET
    } kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [3:0]       cause_q, cause_d;
    logic [31:2]      epc_q, epc_d;
    logic [31:0]      badaddr_q, badaddr_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [31:0]      priv_pc_q, priv_pc_d;
    logic             insert_pc_q, insert_pc_d;
    logic             intr_q, intr_d;
    logic             busy_q, busy_d;
    logic             mepc_wen_q, mepc_wen_d;
    logic             mcause_wen_q, mcause_wen_d;
    logic             mtval_wen_q, mtval_wen_d;
    logic [31:0]      mepc_wdata_q, mepc_wdata_d;
    logic [31:0]      mcause_wdata_q, mcause_wdata_d;
    logic [31:0]      mtval_wdata_q, mtval_wdata_d;
    logic             mstatus_push_q, mstatus_push_d;
    logic             mstatus_pop_q, mstatus_pop_d;

    logic             exc_any;
    logic [3:0]       exc_cause;
    logic [2:0]       irq_vec;
    logic             irq_pend;
    logic [3:0]       irq_cause;
    logic             mtval_valid;
    logic [31:0]      tvec_base;
    logic [31:0]      tvec_vect;
    logic             use_vect;

    // Exception priority chain; first match wins.
    always_comb begin
        exc_any   = 1'b1;
        exc_cause = 4'd0;
        if (trap_if.fault_insn_page)       exc_cause = 4'd12;
        else if (trap_if.fault_insn)       exc_cause = 4'd1;
        else if (trap_if.illegal_insn)     exc_cause = 4'd2;
        else if (trap_if.mal_insn)         exc_cause = 4'd0;
        else if (trap_if.env)              exc_cause = 4'd11;
        else if (trap_if.breakpoint)       exc_cause = 4'd3;
        else if (trap_if.mal_s)            exc_cause = 4'd6;
        else if (trap_if.mal_l)            exc_cause = 4'd4;
        else if (trap_if.fault_store_page) exc_cause = 4'd15;
        else if (trap_if.fault_load_page)  exc_cause = 4'd13;
        else if (trap_if.fault_s)          exc_cause = 4'd7;
        else if (trap_if.fault_l)          exc_cause = 4'd5;
        else                               exc_any   = 1'b0;
    end

    // mie_en is {MEIE,MSIE,MTIE}, so bit order matches {ext,soft,timer}.
    assign irq_vec  = {trap_if.ext_int, trap_if.soft_int, trap_if.timer_int} & trap_if.mie_en;
    assign irq_pend = trap_if.mstatus_mie & (|irq_vec);

    always_comb begin
        if (irq_vec[2])      irq_cause = 4'd11;
        else if (irq_vec[1]) irq_cause = 4'd3;
        else                 irq_cause = 4'd7;
    end

    // mtval carries badaddr purely by cause code, regardless of trap kind.
    always_comb begin
        case (cause_q)
            4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13, 4'd15: mtval_valid = 1'b1;
            default:                                                 mtval_valid = 1'b0;
        endcase
    end

    // MODE 2'b1x falls through to direct mode.
    assign tvec_base = {trap_if.mtvec[31:2], 2'b00};
    assign tvec_vect = tvec_base + {26'd0, cause_q, 2'b00};
    assign use_vect  = VECTORED_EN && (kind_q == KIND_IRQ) && (trap_if.mtvec[1:0] == 2'b01);

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        cause_d        = cause_q;
        epc_d          = epc_q;
        badaddr_d      = badaddr_q;
        wait_cnt_d     = wait_cnt_q;
        priv_pc_d      = 32'd0;
        insert_pc_d    = 1'b0;
        intr_d         = 1'b0;
        mepc_wen_d     = 1'b0;
        mcause_wen_d   = 1'b0;
        mtval_wen_d    = 1'b0;
        mepc_wdata_d   = 32'd0;
        mcause_wdata_d = 32'd0;
        mtval_wdata_d  = 32'd0;
        mstatus_push_d = 1'b0;
        mstatus_pop_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (exc_any || irq_pend || trap_if.mret) begin
                    state_d    = ST_WAIT_CLEAR;
                    wait_cnt_d = '0;
                    epc_d      = trap_if.epc[31:2];
                    badaddr_d  = trap_if.badaddr;
                    if (exc_any) begin
                        kind_d  = KIND_EXC;
                        cause_d = exc_cause;
                    end else if (irq_pend) begin
                        kind_d  = KIND_IRQ;
                        cause_d = irq_cause;
                    end else begin
                        kind_d  = KIND_RET;
                        cause_d = 4'd0;
                    end
                end
            end

            ST_WAIT_CLEAR: begin
                if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
                // A stalled EX/MEM must never see CSR writes, even after the
                // drain timeout has expired.
                if (!trap_if.ex_mem_stall && (trap_if.pipe_clear || wait_cnt_q == CNT_MAX)) begin
                    state_d = ST_COMMIT;
                    if (kind_q == KIND_RET) begin
                        mstatus_pop_d = 1'b1;
                    end else begin
                        mepc_wen_d     = 1'b1;
                        mcause_wen_d   = 1'b1;
                        mtval_wen_d    = 1'b1;
                        mstatus_push_d = 1'b1;
                        mepc_wdata_d   = {epc_q, 2'b00};
                        mcause_wdata_d = {kind_q == KIND_IRQ, 27'd0, cause_q};
                        mtval_wdata_d  = mtval_valid ? badaddr_q : 32'd0;
                    end
                end
            end

            ST_COMMIT: begin
                state_d     = ST_REDIRECT;
                insert_pc_d = 1'b1;
                intr_d      = (kind_q == KIND_IRQ);
                if (kind_q == KIND_RET) begin
                    priv_pc_d = trap_if.mepc_r;
                end else if (use_vect) begin
                    priv_pc_d = tvec_vect;
                end else begin
                    priv_pc_d = tvec_base;
                end
            end

            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            kind_q         <= KIND_EXC;
            cause_q        <= 4'd0;
            epc_q          <= '0;
            badaddr_q      <= 32'd0;
            wait_cnt_q     <= '0;
            priv_pc_q      <= 32'd0;
            insert_pc_q    <= 1'b0;
            intr_q         <= 1'b0;
            busy_q         <= 1'b0;
            mepc_wen_q     <= 1'b0;
            mcause_wen_q   <= 1'b0;
            mtval_wen_q    <= 1'b0;
            mepc_wdata_q   <= 32'd0;
            mcause_wdata_q <= 32'd0;
            mtval_wdata_q  <= 32'd0;
            mstatus_push_q <= 1'b0;
            mstatus_pop_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            cause_q        <= cause_d;
            epc_q          <= epc_d;
            badaddr_q      <= badaddr_d;
            wait_cnt_q     <= wait_cnt_d;
            priv_pc_q      <= priv_pc_d;
            insert_pc_q    <= insert_pc_d;
            intr_q         <= intr_d;
            busy_q         <= busy_d;
            mepc_wen_q     <= mepc_wen_d;
            mcause_wen_q   <= mcause_wen_d;
            mtval_wen_q    <= mtval_wen_d;
            mepc_wdata_q   <= mepc_wdata_d;
            mcause_wdata_q <= mcause_wdata_d;
            mtval_wdata_q  <= mtval_wdata_d;
            mstatus_push_q <= mstatus_push_d;
            mstatus_pop_q  <= mstatus_pop_d;
        end
    end

    assign trap_if.priv_pc      = priv_pc_q;
    assign trap_if.insert_pc    = insert_pc_q;
    assign trap_if.intr         = intr_q;
    assign trap_if.busy         = busy_q;
    assign trap_if.mepc_wen     = mepc_wen_q;
    assign trap_if.mcause_wen   = mcause_wen_q;
    assign trap_if.mtval_wen    = mtval_wen_q;
    assign trap_if.mepc_wdata   = mepc_wdata_q;
    assign trap_if.mcause_wdata = mcause_wdata_q;
    assign trap_if.mtval_wdata  = mtval_wdata_q;
    assign trap_if.mstatus_push = mstatus_push_q;
    assign trap_if.mstatus_pop  = mstatus_pop_q;

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// tb/tb_priv_trap_sequencer.sv - self-checking bench for priv_trap_sequencer
module tb_priv_trap_sequencer;

    localparam int WAIT_MAX = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    priv_trap_sequencer_if tif();

    priv_trap_sequencer #(
        .VECTORED_EN (1'b1),
        .WAIT_MAX    (WAIT_MAX)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .trap_if (tif)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Exception flags in priority order (index 0 highest) and their causes.
    int exc_cause_tab [12] = '{12, 1, 2, 0, 11, 3, 6, 4, 15, 13, 7, 5};
    // Interrupts in priority order: ext, soft, timer.
    int irq_cause_tab [3]  = '{11, 3, 7};

    logic [11:0] cur_exc;
    logic [2:0]  cur_irq;      // {ext, soft, timer}
    logic        cur_mie;
    logic [2:0]  cur_mie_en;
    logic        cur_mret;
    logic [31:0] cur_epc, cur_badaddr, cur_mtvec, cur_mepc_r;

    bit          exp_trig;
    int          exp_kind;     // 0 exception, 1 interrupt, 2 mret
    int          exp_cause;
    logic [31:0] exp_mepc, exp_mcause, exp_mtval, exp_pc;
    logic [3:0]  exp_wens;
    logic        exp_pop, exp_intr;

    int          obs_commit, obs_redir, obs_npulse, obs_nstrobe, obs_stray;
    int          obs_nbusy, obs_busy_gap;
    logic        obs_busy_end;
    logic [3:0]  obs_wens;
    logic        obs_pop, obs_intr;
    logic [31:0] obs_mepc, obs_mcause, obs_mtval, obs_pc;

    task automatic drive_exc(input logic [11:0] v);
        tif.fault_insn_page  = v[0];
        tif.fault_insn       = v[1];
        tif.illegal_insn     = v[2];
        tif.mal_insn         = v[3];
        tif.env              = v[4];
        tif.breakpoint       = v[5];
        tif.mal_s            = v[6];
        tif.mal_l            = v[7];
        tif.fault_store_page = v[8];
        tif.fault_load_page  = v[9];
        tif.fault_s          = v[10];
        tif.fault_l          = v[11];
    endtask

    task automatic clear_trigger();
        drive_exc(12'd0);
        tif.ext_int   = 1'b0;
        tif.soft_int  = 1'b0;
        tif.timer_int = 1'b0;
        tif.mret      = 1'b0;
    endtask

    task automatic noise_lines();
        drive_exc(12'($urandom));
        {tif.ext_int, tif.soft_int, tif.timer_int} = 3'($urandom);
        tif.mret    = 1'($urandom);
        tif.epc     = $urandom;
        tif.badaddr = $urandom;
    endtask

    task automatic apply_trigger();
        drive_exc(cur_exc);
        {tif.ext_int, tif.soft_int, tif.timer_int} = cur_irq;
        tif.mstatus_mie = cur_mie;
        tif.mie_en      = cur_mie_en;
        tif.mret        = cur_mret;
        tif.epc         = cur_epc;
        tif.badaddr     = cur_badaddr;
        tif.mtvec       = cur_mtvec;
        tif.mepc_r      = cur_mepc_r;
    endtask

    task automatic set_idle_defaults();
        cur_exc = '0; cur_irq = '0; cur_mie = 1'b0; cur_mie_en = '0; cur_mret = 1'b0;
        cur_epc = '0; cur_badaddr = '0; cur_mtvec = '0; cur_mepc_r = '0;
    endtask

    // Reference model: what the trap should look like from the rules alone.
    task automatic compute_expected();
        int idx;
        logic [2:0] pend;
        logic [31:0] base;
        idx = -1;
        for (int i = 0; i < 12; i++) if (cur_exc[i] && idx < 0) idx = i;
        pend = cur_irq & cur_mie_en;
        exp_trig = 1'b1;
        exp_cause = 0;
        if (idx >= 0) begin
            exp_kind = 0; exp_cause = exc_cause_tab[idx];
        end else if (cur_mie && pend != 3'd0) begin
            exp_kind = 1;
            for (int i = 2; i >= 0; i--) if (pend[i] && exp_cause == 0) exp_cause = irq_cause_tab[2 - i];
        end else if (cur_mret) begin
            exp_kind = 2;
        end else begin
            exp_trig = 1'b0; exp_kind = 2;
        end
        base = cur_mtvec & 32'hFFFF_FFFC;
        if (exp_kind == 2) begin
            exp_wens = 4'b0000; exp_pop = 1'b1;
            exp_mepc = 0; exp_mcause = 0; exp_mtval = 0;
            exp_pc = cur_mepc_r; exp_intr = 1'b0;
        end else begin
            exp_wens   = 4'b1111; exp_pop = 1'b0;
            exp_mepc   = cur_epc & 32'hFFFF_FFFC;
            exp_mcause = (exp_kind == 1 ? 32'h8000_0000 : 32'h0) + exp_cause;
            exp_mtval  = (exp_cause inside {0, 1, 4, 5, 6, 7, 12, 13, 15}) ? cur_badaddr : 32'h0;
            exp_intr   = (exp_kind == 1);
            exp_pc     = (exp_kind == 1 && cur_mtvec[1:0] == 2'b01) ? base + 32'(exp_cause * 4) : base;
        end
    endtask

    // Cycle in which WAIT_CLEAR is left, counting the trigger cycle as 0.
    function automatic int leave_cycle(input int clear_at, input int stall_until);
        int g;
        g = (clear_at < WAIT_MAX + 1) ? clear_at : WAIT_MAX + 1;
        if (g < stall_until) g = stall_until;
        if (g < 1) g = 1;
        return g;
    endfunction

    // Caller drives the trigger at cycle 0 (just after a rising edge); this
    // task runs cycles and records what the DUT does, ending aligned.
    task automatic run_seq(input int clear_at, input int stall_until, input bit noise, input int max_cyc);
        logic strobe;
        obs_commit = -1; obs_redir = -1; obs_npulse = 0; obs_nstrobe = 0; obs_stray = 0;
        obs_nbusy = 0; obs_busy_gap = 0; obs_busy_end = 1'bx;
        obs_wens = 'x; obs_pop = 1'bx; obs_intr = 1'bx;
        obs_mepc = 'x; obs_mcause = 'x; obs_mtval = 'x; obs_pc = 'x;
        for (int c = 0; c < max_cyc; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (noise && obs_redir < 0) noise_lines();
                else clear_trigger();
            end
            tif.pipe_clear   = (c >= clear_at);
            tif.ex_mem_stall = (c < stall_until);
            @(negedge clk);
            strobe = tif.mepc_wen | tif.mcause_wen | tif.mtval_wen | tif.mstatus_push | tif.mstatus_pop;
            if (strobe) begin
                obs_nstrobe++;
                if (obs_commit < 0) begin
                    obs_commit = c;
                    obs_wens   = {tif.mepc_wen, tif.mcause_wen, tif.mtval_wen, tif.mstatus_push};
                    obs_pop    = tif.mstatus_pop;
                    obs_mepc   = tif.mepc_wdata;
                    obs_mcause = tif.mcause_wdata;
                    obs_mtval  = tif.mtval_wdata;
                end
            end else if ((tif.mepc_wdata | tif.mcause_wdata | tif.mtval_wdata) != 32'd0) begin
                obs_stray++;
            end
            if (tif.insert_pc) begin
                obs_npulse++;
                if (obs_redir < 0) begin
                    obs_redir = c; obs_pc = tif.priv_pc; obs_intr = tif.intr;
                end
            end else if (tif.priv_pc != 32'd0 || tif.intr) begin
                obs_stray++;
            end
            if (tif.busy) obs_nbusy++;
            else if (c >= 1 && obs_redir < 0) obs_busy_gap++;
            if (obs_redir >= 0 && c == obs_redir + 1) begin
                obs_busy_end = tif.busy;
                break;
            end
        end
        clear_trigger();
        tif.pipe_clear = 1'b0;
        tif.ex_mem_stall = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [135:0] all_out;
        set_idle_defaults(); apply_trigger();
        tif.pipe_clear = 1'b1; tif.ex_mem_stall = 1'b0;
        tif.illegal_insn = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        all_out = {tif.busy, tif.insert_pc, tif.intr, tif.mepc_wen, tif.mcause_wen, tif.mtval_wen,
                   tif.mstatus_push, tif.mstatus_pop, tif.priv_pc, tif.mepc_wdata,
                   tif.mcause_wdata, tif.mtval_wdata};
        n_checks++;
        if (all_out !== 136'd0) begin
            n_errors++; $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        @(posedge clk); #1;
        rst = 1'b0; tif.illegal_insn = 1'b0; tif.pipe_clear = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tif.busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_release_busy: got %b required 0", tif.busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        set_idle_defaults();
        cur_exc[2] = 1'b1; cur_epc = 32'h100; cur_mtvec = 32'h8000_0000;
        apply_trigger();
        run_seq(1, 0, 1'b0, 40);
        n_checks++;
        if (obs_commit !== 2) begin n_errors++; $display("FAIL illegal_commit_cycle: got %0d required 2", obs_commit); end
        n_checks++;
        if (obs_redir !== 3) begin n_errors++; $display("FAIL illegal_insert_cycle: got %0d required 3", obs_redir); end
        n_checks++;
        if (obs_pc !== 32'h8000_0000) begin n_errors++; $display("FAIL illegal_priv_pc: got %h required 80000000", obs_pc); end
        n_checks++;
        if (obs_mcause !== 32'h2) begin n_errors++; $display("FAIL illegal_mcause: got %h required 2", obs_mcause); end
        n_checks++;
        if (obs_mtval !== 32'h0) begin n_errors++; $display("FAIL illegal_mtval: got %h required 0", obs_mtval); end
        n_checks++;
        if (obs_mepc !== 32'h100) begin n_errors++; $display("FAIL illegal_mepc: got %h required 100", obs_mepc); end
        n_checks++;
        if (obs_wens !== 4'b1111 || obs_pop !== 1'b0 || obs_intr !== 1'b0) begin
            n_errors++; $display("FAIL illegal_strobes: got wens=%b pop=%b intr=%b required 1111/0/0", obs_wens, obs_pop, obs_intr);
        end
    endtask

    task automatic test_exc_priority();
        set_idle_defaults();
        cur_exc[11] = 1'b1; cur_exc[6] = 1'b1;   // fault_l and mal_s
        cur_badaddr = 32'h2003; cur_epc = 32'h0000_0207; cur_mtvec = 32'h0000_3000;
        apply_trigger();
        run_seq(1, 0, 1'b0, 40);
        n_checks++;
        if (obs_mcause !== 32'h6) begin n_errors++; $display("FAIL prio_mcause: got %h required 6", obs_mcause); end
        n_checks++;
        if (obs_mtval !== 32'h2003) begin n_errors++; $display("FAIL prio_mtval: got %h required 2003", obs_mtval); end
        n_checks++;
        if (obs_mepc !== 32'h204) begin n_errors++; $display("FAIL prio_mepc_align: got %h required 204", obs_mepc); end
    endtask

    task automatic test_vectored_timer();
        set_idle_defaults();
        cur_irq = 3'b001; cur_mie = 1'b1; cur_mie_en = 3'b001; cur_mtvec = 32'h1001; cur_epc = 32'h500;
        apply_trigger();
        run_seq(1, 0, 1'b0, 40);
        n_checks++;
        if (obs_pc !== 32'h101C) begin n_errors++; $display("FAIL vec_priv_pc: got %h required 101c", obs_pc); end
        n_checks++;
        if (obs_mcause !== 32'h8000_0007) begin n_errors++; $display("FAIL vec_mcause: got %h required 80000007", obs_mcause); end
        n_checks++;
        if (obs_intr !== 1'b1) begin n_errors++; $display("FAIL vec_intr: got %b required 1", obs_intr); end
        // MODE 2'b11 is direct even for interrupts.
        set_idle_defaults();
        cur_irq = 3'b100; cur_mie = 1'b1; cur_mie_en = 3'b111; cur_mtvec = 32'h0000_4003;
        apply_trigger();
        run_seq(1, 0, 1'b0, 40);
        n_checks++;
        if (obs_pc !== 32'h4000 || obs_mcause !== 32'h8000_000B) begin
            n_errors++; $display("FAIL mode3_direct: got pc=%h mcause=%h required 4000/8000000b", obs_pc, obs_mcause);
        end
    endtask

    task automatic test_mret();
        set_idle_defaults();
        cur_mret = 1'b1; cur_mepc_r = 32'h400; cur_mtvec = 32'h9000;
        apply_trigger();
        run_seq(1, 0, 1'b0, 40);
        n_checks++;
        if (obs_wens !== 4'b0000 || obs_pop !== 1'b1) begin
            n_errors++; $display("FAIL mret_strobes: got wens=%b pop=%b required 0000/1", obs_wens, obs_pop);
        end
        n_checks++;
        if (obs_pc !== 32'h400 || obs_intr !== 1'b0) begin
            n_errors++; $display("FAIL mret_redirect: got pc=%h intr=%b required 400/0", obs_pc, obs_intr);
        end
        cur_exc[2] = 1'b1;
        apply_trigger();
        run_seq(1, 0, 1'b0, 40);
        n_checks++;
        if (obs_pop !== 1'b0 || obs_mcause !== 32'h2 || obs_pc !== 32'h9000) begin
            n_errors++; $display("FAIL mret_vs_illegal: got pop=%b mcause=%h pc=%h required 0/2/9000", obs_pop, obs_mcause, obs_pc);
        end
    endtask

    task automatic test_timeout_and_stall();
        set_idle_defaults();
        cur_exc[3] = 1'b1; cur_mtvec = 32'h100;
        apply_trigger();
        run_seq(1000, 0, 1'b0, 60);
        n_checks++;
        if (obs_commit !== WAIT_MAX + 2 || obs_redir !== WAIT_MAX + 3) begin
            n_errors++; $display("FAIL timeout_forced: got commit=%0d insert=%0d required %0d/%0d", obs_commit, obs_redir, WAIT_MAX + 2, WAIT_MAX + 3);
        end
        apply_trigger();
        run_seq(1, 40, 1'b0, 60);
        n_checks++;
        if (obs_commit !== 41 || obs_redir !== 42 || obs_busy_gap !== 0) begin
            n_errors++; $display("FAIL stall_hold: got commit=%0d insert=%0d gaps=%0d required 41/42/0", obs_commit, obs_redir, obs_busy_gap);
        end
    endtask

    task automatic test_reset_mid();
        int hits;
        set_idle_defaults();
        cur_exc[2] = 1'b1; cur_mtvec = 32'h700;
        apply_trigger();
        tif.pipe_clear = 1'b0; tif.ex_mem_stall = 1'b0;
        @(posedge clk); #1; clear_trigger();
        @(negedge clk);
        n_checks++;
        if (tif.busy !== 1'b1) begin n_errors++; $display("FAIL midrst_busy_before: got %b required 1", tif.busy); end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; tif.pipe_clear = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tif.busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy_after: got %b required 0", tif.busy); end
        hits = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tif.insert_pc || tif.mepc_wen || tif.mcause_wen || tif.mtval_wen ||
                tif.mstatus_push || tif.mstatus_pop || tif.busy) hits++;
        end
        n_checks++;
        if (hits !== 0) begin n_errors++; $display("FAIL midrst_quiet: got %0d active cycles required 0", hits); end
        tif.pipe_clear = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int clear_at, stall_until, r;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      cur_exc = '0;
            else if (r == 1) cur_exc = 12'd1 << $urandom_range(0, 11);
            else             cur_exc = 12'($urandom) & 12'($urandom) & 12'($urandom);
            cur_irq = 3'($urandom); cur_mie = 1'($urandom); cur_mie_en = 3'($urandom);
            cur_mret = 1'($urandom);
            cur_epc = $urandom; cur_badaddr = $urandom; cur_mepc_r = $urandom;
            cur_mtvec = $urandom;
            if ($urandom_range(0, 1) == 1) cur_mtvec[1:0] = 2'b01;
            clear_at = $urandom_range(1, 20);
            stall_until = $urandom_range(0, 20);
            compute_expected();
            apply_trigger();
            if (!exp_trig) begin
                run_seq(clear_at, stall_until, 1'b0, 4);
                n_checks++;
                if (obs_nbusy !== 0 || obs_npulse !== 0 || obs_nstrobe !== 0) begin
                    n_errors++; $display("FAIL rnd%0d_no_trigger: got busy=%0d pulses=%0d strobes=%0d required 0/0/0", it, obs_nbusy, obs_npulse, obs_nstrobe);
                end
                continue;
            end
            run_seq(clear_at, stall_until, 1'b1, 60);
            n_checks++;
            if (obs_commit !== leave_cycle(clear_at, stall_until) + 1 || obs_redir !== leave_cycle(clear_at, stall_until) + 2) begin
                n_errors++; $display("FAIL rnd%0d_timing: got commit=%0d insert=%0d required %0d/%0d", it, obs_commit, obs_redir,
                                     leave_cycle(clear_at, stall_until) + 1, leave_cycle(clear_at, stall_until) + 2);
            end
            n_checks++;
            if (obs_wens !== exp_wens || obs_pop !== exp_pop) begin
                n_errors++; $display("FAIL rnd%0d_strobes: got wens=%b pop=%b required %b/%b", it, obs_wens, obs_pop, exp_wens, exp_pop);
            end
            n_checks++;
            if (obs_mepc !== exp_mepc || obs_mcause !== exp_mcause || obs_mtval !== exp_mtval) begin
                n_errors++; $display("FAIL rnd%0d_csr_data: got %h/%h/%h required %h/%h/%h", it, obs_mepc, obs_mcause, obs_mtval, exp_mepc, exp_mcause, exp_mtval);
            end
            n_checks++;
            if (obs_pc !== exp_pc || obs_intr !== exp_intr) begin
                n_errors++; $display("FAIL rnd%0d_redirect: got pc=%h intr=%b required %h/%b", it, obs_pc, obs_intr, exp_pc, exp_intr);
            end
            n_checks++;
            if (obs_npulse !== 1 || obs_nstrobe !== 1 || obs_stray !== 0 || obs_busy_gap !== 0 || obs_busy_end !== 1'b0) begin
                n_errors++; $display("FAIL rnd%0d_framing: got pulses=%0d strobes=%0d stray=%0d gaps=%0d busy_end=%b required 1/1/0/0/0",
                                     it, obs_npulse, obs_nstrobe, obs_stray, obs_busy_gap, obs_busy_end);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle_defaults();
        apply_trigger();
        tif.pipe_clear = 1'b0;
        tif.ex_mem_stall = 1'b0;
        test_reset();
        test_illegal();
        test_exc_priority();
        test_vectored_timer();
        test_mret();
        test_timeout_and_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
